// File: rtl/sv_sig_ser_pkg.sv
// Shared definitions for the signature serializer: FSM state encoding and
// the frame-length helper used by integrators and benches.
package sv_sig_ser_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND_R   = 2'd1,
        ST_SEND_S   = 2'd2,
        ST_SEND_CHK = 2'd3
    } fsm_state;

    // Bytes per frame: r and s scalars plus the optional checksum byte.
    function automatic int sig_frame_len(input int block_size, input int chk_en);
        int len;
        len = 2 * (block_size / 8);
        if (chk_en != 0) begin
            len = len + 1;
        end else begin
            len = len + 0;
        end
        return len;
    endfunction

endpackage

// File: rtl/sv_sig_ser.sv
// Signature serializer: captures the (r, s) scalar pair on a core completion
// strobe and streams it out byte by byte over a valid/ready interface,
// optionally followed by an XOR checksum byte.
module sv_sig_ser
    import sv_sig_ser_pkg::*;
#(
    parameter int BLOCK_SIZE = 256,
    parameter int CHK_EN     = 1
) (
    input  logic                  clk,
    input  logic                  areset,
    input  logic                  v_i,
    input  logic [BLOCK_SIZE-1:0] sig_r,
    input  logic [BLOCK_SIZE-1:0] sig_s,
    output logic [7:0]            data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic                  last_o,
    output logic                  overrun_o,
    output logic                  ready
);

    localparam int                N        = BLOCK_SIZE / 8;
    localparam int                CNT_W    = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(N - 1);
    localparam bit                CHK_ON   = (CHK_EN != 0);

    fsm_state              state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [CNT_W-1:0]      cnt_nxt_s;
    logic [7:0]            chk_q, chk_d;
    logic [7:0]            data_q, data_d;
    logic                  valid_q, valid_d;
    logic                  last_q, last_d;
    logic                  ready_q, ready_d;
    logic                  overrun_q, overrun_d;
    logic [BLOCK_SIZE-1:0] buf_r_q, buf_r_d;
    logic [BLOCK_SIZE-1:0] buf_s_q, buf_s_d;
    logic                  xfer_s;

    // Inline byte-select mux: byte idx of a captured scalar (byte 0 = LSBs).
    function automatic logic [7:0] pick_byte(input logic [BLOCK_SIZE-1:0] vec,
                                             input logic [CNT_W-1:0]      idx);
        logic [BLOCK_SIZE-1:0] shifted;
        shifted = vec >> {idx, 3'b000};
        return shifted[7:0];
    endfunction

    assign xfer_s    = valid_q & ready_i;
    assign cnt_nxt_s = cnt_q + CNT_W'(1);

    // Next-state, counter, checksum and next output byte; outputs are all
    // registered, so the byte for the following beat is selected here.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        chk_d     = chk_q;
        data_d    = data_q;
        valid_d   = valid_q;
        last_d    = last_q;
        ready_d   = ready_q;
        buf_r_d   = buf_r_q;
        buf_s_d   = buf_s_q;

        // A strobe outside IDLE is lost; remember it until reset.
        if ((state_q != ST_IDLE) && v_i) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (v_i) begin
                    buf_r_d = sig_r;
                    buf_s_d = sig_s;
                    state_d = ST_SEND_R;
                    cnt_d   = '0;
                    chk_d   = 8'h00;
                    data_d  = sig_r[7:0];
                    valid_d = 1'b1;
                    last_d  = 1'b0;
                    ready_d = 1'b0;
                end else begin
                    ready_d = 1'b1;
                end
            end
            ST_SEND_R: begin
                if (xfer_s) begin
                    chk_d = chk_q ^ data_q;
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_SEND_S;
                        cnt_d   = '0;
                        data_d  = pick_byte(buf_s_q, '0);
                        last_d  = !CHK_ON && (N == 1);
                    end else begin
                        cnt_d  = cnt_nxt_s;
                        data_d = pick_byte(buf_r_q, cnt_nxt_s);
                        last_d = 1'b0;
                    end
                end else begin
                    chk_d = chk_q;
                end
            end
            ST_SEND_S: begin
                if (xfer_s) begin
                    chk_d = chk_q ^ data_q;
                    if (cnt_q == CNT_LAST) begin
                        cnt_d = '0;
                        if (CHK_ON) begin
                            // The byte leaving now is folded in directly.
                            state_d = ST_SEND_CHK;
                            data_d  = chk_q ^ data_q;
                            last_d  = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            data_d  = 8'h00;
                            valid_d = 1'b0;
                            last_d  = 1'b0;
                            ready_d = 1'b1;
                        end
                    end else begin
                        cnt_d  = cnt_nxt_s;
                        data_d = pick_byte(buf_s_q, cnt_nxt_s);
                        last_d = !CHK_ON && (cnt_nxt_s == CNT_LAST);
                    end
                end else begin
                    chk_d = chk_q;
                end
            end
            ST_SEND_CHK: begin
                if (xfer_s) begin
                    state_d = ST_IDLE;
                    data_d  = 8'h00;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    ready_d = 1'b1;
                end else begin
                    state_d = ST_SEND_CHK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                chk_d   = 8'h00;
                data_d  = 8'h00;
                valid_d = 1'b0;
                last_d  = 1'b0;
                ready_d = 1'b1;
            end
        endcase
    end

    // Control and output registers with synchronous reset; reset wins over v_i.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            chk_q     <= 8'h00;
            data_q    <= 8'h00;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            ready_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            chk_q     <= chk_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            last_q    <= last_d;
            ready_q   <= ready_d;
            overrun_q <= overrun_d;
        end
    end

    // Capture buffers carry no reset: their content is irrelevant until the
    // next capture, which always rewrites both.
    always_ff @(posedge clk) begin
        buf_r_q <= buf_r_d;
        buf_s_q <= buf_s_d;
    end

    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign last_o    = last_q;
    assign overrun_o = overrun_q;
    assign ready     = ready_q;

endmodule
